// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: Tuse/Tnew timing
// per instruction class and the default mult/div latencies.
package pipe_hazard_ctrl_pkg;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] tick_t;

  // Default mult/div unit latencies and the countdown width that holds them.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // Tuse: cycles until a D-stage source operand is consumed.
  localparam tick_t TUSE_BRANCH   = 2'd0;  // beq/bne/jr compare in D
  localparam tick_t TUSE_ALU      = 2'd1;  // ALU operands consumed in E
  localparam tick_t TUSE_STORE_RT = 2'd2;  // store data consumed in M
  localparam tick_t TUSE_NONE     = 2'd3;  // operand unused; never stalls

  // Tnew: cycles until a producer's result can be forwarded.
  localparam tick_t TNEW_NONE   = 2'd0;
  localparam tick_t TNEW_ALU_E  = 2'd1;
  localparam tick_t TNEW_LOAD_E = 2'd2;
  localparam tick_t TNEW_LOAD_M = 2'd1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard bus between the pipeline datapath (master) and the stall/flush
// sequencer (slave).
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  reg_idx_t    rs_D;
  reg_idx_t    rt_D;
  tick_t       tuse_rs_D;
  tick_t       tuse_rt_D;
  logic        md_use_D;
  reg_idx_t    a3_E;
  tick_t       tnew_E;
  reg_idx_t    a3_M;
  tick_t       tnew_M;
  logic        md_start_E;
  logic        md_div_E;
  logic        en_pc;
  logic        en_D;
  logic        clr_E;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    output a3_E, tnew_E, a3_M, tnew_M, md_start_E, md_div_E,
    input  en_pc, en_D, clr_E, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
    input  a3_E, tnew_E, a3_M, tnew_M, md_start_E, md_div_E,
    output en_pc, en_D, clr_E, md_busy, md_done, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Busy countdown for the multi-cycle mult/div unit. A start while idle loads
// the op latency; busy holds for exactly that many cycles after the start edge.
module pipe_hazard_ctrl_md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load on an idle start (a start while busy is ignored), else count down to zero.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (start && (count_q == '0)) begin
      count_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Countdown register; synchronous reset also aborts a countdown in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign busy = (count_q != '0);
  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Stalls hold PC and
// F/D and inject a bubble into D/E; E/M and M/W always advance.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        stall;
  logic        md_busy;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  pipe_hazard_ctrl_md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.md_start_E),
    .is_div (hz.md_div_E),
    .busy   (md_busy),
    .done   (hz.md_done)
  );

  // Operand hazards: a producer in E/M whose result is not ready before the
  // consumer needs it. Register $0 is never a real dependency.
  always_comb begin
    stall_rs = (hz.rs_D != '0) &&
               (((hz.rs_D == hz.a3_E) && (hz.tnew_E > hz.tuse_rs_D)) ||
                ((hz.rs_D == hz.a3_M) && (hz.tnew_M > hz.tuse_rs_D)));
    stall_rt = (hz.rt_D != '0) &&
               (((hz.rt_D == hz.a3_E) && (hz.tnew_E > hz.tuse_rt_D)) ||
                ((hz.rt_D == hz.a3_M) && (hz.tnew_M > hz.tuse_rt_D)));
    // The start cycle itself already blocks the next mult/div-class instr.
    stall_md = hz.md_use_D && (md_busy || hz.md_start_E);
    stall    = stall_rs || stall_rt || stall_md;
  end

  assign hz.en_pc   = ~stall;
  assign hz.en_D    = ~stall;
  assign hz.clr_E   = stall;
  assign hz.md_busy = md_busy;

  // Stall counter next value: one per stalled cycle, wrapping at 2^32.
  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // Stall performance counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by randomized traffic, all compared against a cycle-indexed reference model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int          n_vec = 0;
  int          n_err = 0;
  // Reference model: the current cycle index, the index of the last busy
  // cycle of the current mult/div op (-1 when none), and the stall total.
  int          cyc = 0;
  int          last_busy = -1;
  logic [31:0] exp_cnt = '0;
  int          busy_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit src_stall(input logic [4:0] src, input logic [1:0] tuse);
    if (src == 5'd0) return 1'b0;
    return ((src == hz.a3_E) && (int'(hz.tnew_E) > int'(tuse))) ||
           ((src == hz.a3_M) && (int'(hz.tnew_M) > int'(tuse)));
  endfunction

  function automatic bit model_busy();
    return cyc <= last_busy;
  endfunction

  function automatic bit model_stall();
    return src_stall(hz.rs_D, hz.tuse_rs_D) || src_stall(hz.rt_D, hz.tuse_rt_D) ||
           (hz.md_use_D && (model_busy() || hz.md_start_E));
  endfunction

  task automatic idle();
    reset         = 1'b0;
    hz.rs_D       = 5'd0;
    hz.rt_D       = 5'd0;
    hz.tuse_rs_D  = TUSE_NONE;
    hz.tuse_rt_D  = TUSE_NONE;
    hz.md_use_D   = 1'b0;
    hz.a3_E       = 5'd0;
    hz.tnew_E     = TNEW_NONE;
    hz.a3_M       = 5'd0;
    hz.tnew_M     = TNEW_NONE;
    hz.md_start_E = 1'b0;
    hz.md_div_E   = 1'b0;
  endtask

  // One clock: check all outputs mid-cycle, then advance the model at the edge.
  // exp_stall >= 0 adds a directed expectation on the stall decision.
  task automatic step(input int exp_stall);
    bit s;
    @(negedge clk);
    s = model_stall();
    check("en_pc",     {31'd0, hz.en_pc},   {31'd0, !s});
    check("en_D",      {31'd0, hz.en_D},    {31'd0, !s});
    check("clr_E",     {31'd0, hz.clr_E},   {31'd0, s});
    check("md_busy",   {31'd0, hz.md_busy}, {31'd0, model_busy()});
    check("md_done",   {31'd0, hz.md_done}, {31'd0, (cyc == last_busy)});
    check("stall_cnt", hz.stall_cnt, exp_cnt);
    if (exp_stall >= 0) check("dir_stall", {31'd0, hz.clr_E}, exp_stall[31:0]);
    if (hz.md_busy) busy_seen++;
    @(posedge clk);
    if (reset) begin
      last_busy = -1;
      exp_cnt   = '0;
    end else begin
      if (s) exp_cnt = exp_cnt + 32'd1;
      if (hz.md_start_E && !model_busy())
        last_busy = cyc + (hz.md_div_E ? DIV_N : MULT_N);
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step(-1);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step(-1);
    step(-1);
    reset = 1'b0;
    check("rst_cnt", hz.stall_cnt, 32'd0);

    // Load-use: lw $8 in E, addu uses $8 in D; next cycle lw is in M.
    hz.rs_D = 5'd8; hz.tuse_rs_D = TUSE_ALU;
    hz.a3_E = 5'd8; hz.tnew_E = TNEW_LOAD_E;
    step(1);
    hz.a3_E = 5'd0; hz.tnew_E = TNEW_NONE;
    hz.a3_M = 5'd8; hz.tnew_M = TNEW_LOAD_M;
    step(0);
    check("lu_cnt", hz.stall_cnt, 32'd1);

    // Branch after ALU, then the a3_E = 0 and tuse = 3 variants.
    idle();
    hz.rs_D = 5'd9; hz.tuse_rs_D = TUSE_BRANCH;
    hz.a3_E = 5'd9; hz.tnew_E = TNEW_ALU_E;
    step(1);
    hz.a3_E = 5'd0;
    step(0);
    hz.a3_E = 5'd9; hz.tuse_rs_D = TUSE_NONE;
    step(0);
    // Store data on rt: load result arrives in time for M, no stall.
    idle();
    hz.rt_D = 5'd9; hz.tuse_rt_D = TUSE_STORE_RT;
    hz.a3_E = 5'd9; hz.tnew_E = TNEW_LOAD_E;
    step(0);
    // rt branch against a load still in M.
    idle();
    hz.rt_D = 5'd7; hz.tuse_rt_D = TUSE_BRANCH;
    hz.a3_M = 5'd7; hz.tnew_M = TNEW_LOAD_M;
    step(1);
    // $0 guard.
    idle();
    hz.rs_D = 5'd0; hz.tuse_rs_D = TUSE_BRANCH;
    hz.a3_E = 5'd0; hz.tnew_E = TNEW_LOAD_E;
    step(0);

    // Mult then mflo: start cycle plus 5 busy cycles stalled.
    do_reset();
    hz.md_use_D = 1'b1; hz.md_start_E = 1'b1; hz.md_div_E = 1'b0;
    step(1);
    hz.md_start_E = 1'b0;
    busy_seen = 0;
    repeat (MULT_N) step(1);
    step(0);
    check("mult_busy_n", busy_seen, MULT_N);
    check("mult_cnt", hz.stall_cnt, 32'd6);

    // Div interrupted by reset at busy cycle 4, then a clean div.
    do_reset();
    hz.md_use_D = 1'b1; hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
    step(1);
    hz.md_start_E = 1'b0;
    repeat (3) step(1);
    reset = 1'b1;
    step(-1);
    reset = 1'b0;
    hz.md_use_D = 1'b0;
    check("rst_md_busy", {31'd0, hz.md_busy}, 32'd0);
    check("rst_md_done", {31'd0, hz.md_done}, 32'd0);
    check("rst_stall_cnt", hz.stall_cnt, 32'd0);
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
    step(0);
    hz.md_start_E = 1'b0;
    busy_seen = 0;
    repeat (DIV_N + 1) step(0);
    check("div_busy_n", busy_seen, DIV_N);

    // Start while busy is ignored: busy ends after the original 5 cycles.
    do_reset();
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b0;
    step(0);
    hz.md_start_E = 1'b0;
    busy_seen = 0;
    step(-1);
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
    step(-1);
    hz.md_start_E = 1'b0;
    repeat (4) step(-1);
    check("reload_busy_n", busy_seen, MULT_N);

    // Randomized traffic over a small register window to force matches.
    do_reset();
    repeat (3000) begin
      reset         = ($urandom_range(0, 99) == 0);
      hz.rs_D       = 5'($urandom_range(0, 3));
      hz.rt_D       = 5'($urandom_range(0, 3));
      hz.tuse_rs_D  = 2'($urandom_range(0, 3));
      hz.tuse_rt_D  = 2'($urandom_range(0, 3));
      hz.a3_E       = 5'($urandom_range(0, 3));
      hz.tnew_E     = 2'($urandom_range(0, 2));
      hz.a3_M       = 5'($urandom_range(0, 3));
      hz.tnew_M     = 2'($urandom_range(0, 2));
      hz.md_use_D   = ($urandom_range(0, 3) == 0);
      hz.md_start_E = ($urandom_range(0, 7) == 0);
      hz.md_div_E   = 1'($urandom_range(0, 1));
      step(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
